// File: rtl/ei_axi4_slave_mem.sv
// ei_axi4_slave_mem: AXI4 slave backed by a word-addressed RAM.
// The write path (AW/W/B) and the read path (AR/R) are independent FSMs.
// Each path holds at most one transaction at a time.
// Ports:
//   aclk, areset            clock and synchronous active-high reset
//   aw*/w*/b*               write address, write data and write response
//   ar*/r*                  read address and read data
// Bursts supported: FIXED, INCR and WRAP, len 0..255.
// Responses: SLVERR for illegal burst parameters, which also suppresses
// all writes. DECERR for any beat whose address falls outside the RAM.
module ei_axi4_slave_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int MAW   = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH * BYTES);
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Address of the beat after 'a'. WRAP folds back to the window's lower bound.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
      input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] step, nxt, wsize, lower;
    step  = ADDR_WIDTH'(1) << size;
    nxt   = (a & ~(step - ADDR_WIDTH'(1))) + step;
    wsize = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
    lower = a & ~(wsize - ADDR_WIDTH'(1));
    case (burst)
      2'b00:   next_addr = a;
      2'b10:   next_addr = (nxt >= lower + wsize) ? lower : nxt;
      default: next_addr = nxt;
    endcase
  endfunction

  function automatic logic bad_params(input logic [7:0] len, input logic [2:0] size,
      input logic [1:0] burst);
    bad_params = (burst == 2'b11) || (size > 3'(BSH)) ||
                 ((burst == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction

  // The encoding is ordered by severity, so a numeric max merges two responses.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    resp_max = (a > b) ? a : b;
  endfunction

  // ---------------------------------------------------------------- write path
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  wstate_t w_state_q, w_state_d;
  logic awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [ID_WIDTH-1:0]   wid_q, wid_d, bid_q, bid_d;
  logic [1:0]            bresp_q, bresp_d, werr_q, werr_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [7:0]            wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [2:0]            wsize_q, wsize_d;
  logic [1:0]            wburst_q, wburst_d;
  logic                  wbad_q, wbad_d;
  logic                  mem_we, w_oob;
  logic [1:0]            beat_resp;

  always_comb begin
    w_state_d = w_state_q; awready_d = awready_q; wready_d = wready_q;
    bvalid_d = bvalid_q;   wid_d = wid_q;         bid_d = bid_q;
    bresp_d = bresp_q;     werr_d = werr_q;       waddr_d = waddr_q;
    wlen_d = wlen_q;       wcnt_d = wcnt_q;       wsize_d = wsize_q;
    wburst_d = wburst_q;   wbad_d = wbad_q;
    mem_we = 1'b0;
    w_oob = waddr_q >= MEM_BYTES;
    beat_resp = werr_q;
    case (w_state_q)
      W_IDLE: if (awvalid && awready_q) begin
        wid_d = awid; waddr_d = awaddr; wlen_d = awlen; wsize_d = awsize; wburst_d = awburst;
        wbad_d = bad_params(awlen, awsize, awburst);
        werr_d = wbad_d ? RESP_SLVERR : RESP_OKAY;
        wcnt_d = 8'd0; awready_d = 1'b0; wready_d = 1'b1; w_state_d = W_DATA;
      end
      W_DATA: if (wvalid && wready_q) begin
        if (w_oob) beat_resp = resp_max(beat_resp, RESP_DECERR);
        if (wlast != (wcnt_q == wlen_q)) beat_resp = resp_max(beat_resp, RESP_SLVERR);
        mem_we  = !wbad_q && !w_oob;
        werr_d  = beat_resp;
        waddr_d = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
        wcnt_d  = wcnt_q + 8'd1;
        // The beat count, not wlast, decides where the burst ends.
        if (wcnt_q == wlen_q) begin
          wready_d = 1'b0; bvalid_d = 1'b1; bresp_d = beat_resp; bid_d = wid_q;
          w_state_d = W_RESP;
        end
      end
      W_RESP: if (bready && bvalid_q) begin
        bvalid_d = 1'b0; awready_d = 1'b1; w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state_q <= W_IDLE; awready_q <= 1'b1; wready_q <= 1'b0; bvalid_q <= 1'b0;
      bid_q <= '0; bresp_q <= RESP_OKAY; wid_q <= '0; werr_q <= RESP_OKAY;
      waddr_q <= '0; wlen_q <= '0; wcnt_q <= '0; wsize_q <= '0; wburst_q <= '0; wbad_q <= 1'b0;
    end else begin
      w_state_q <= w_state_d; awready_q <= awready_d; wready_q <= wready_d; bvalid_q <= bvalid_d;
      bid_q <= bid_d; bresp_q <= bresp_d; wid_q <= wid_d; werr_q <= werr_d;
      waddr_q <= waddr_d; wlen_q <= wlen_d; wcnt_q <= wcnt_d; wsize_q <= wsize_d;
      wburst_q <= wburst_d; wbad_q <= wbad_d;
    end
  end

  // RAM is not reset; a beat coinciding with reset is dropped.
  always_ff @(posedge aclk) begin
    if (mem_we && !areset)
      for (int b = 0; b < BYTES; b++)
        if (wstrb[b]) mem[waddr_q[BSH +: MAW]][8*b +: 8] <= wdata[8*b +: 8];
  end

  // ----------------------------------------------------------------- read path
  typedef enum logic {R_IDLE, R_DATA} rstate_t;
  rstate_t r_state_q, r_state_d;
  logic arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d, rburst_q, rburst_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d, rd_addr;
  logic [7:0]            rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [2:0]            rsize_q, rsize_d;
  logic                  rbad_q, rbad_d, rd_load, rd_oob;

  always_comb begin
    r_state_d = r_state_q; arready_d = arready_q; rvalid_d = rvalid_q; rlast_d = rlast_q;
    rid_d = rid_q; rdata_d = rdata_q; rresp_d = rresp_q; rburst_d = rburst_q;
    raddr_d = raddr_q; rlen_d = rlen_q; rcnt_d = rcnt_q; rsize_d = rsize_q; rbad_d = rbad_q;
    rd_addr = raddr_q; rd_load = 1'b0;
    case (r_state_q)
      R_IDLE: if (arvalid && arready_q) begin
        rid_d = arid; raddr_d = araddr; rlen_d = arlen; rsize_d = arsize; rburst_d = arburst;
        rbad_d = bad_params(arlen, arsize, arburst);
        rd_addr = araddr; rd_load = 1'b1; rcnt_d = 8'd0;
        rlast_d = (arlen == 8'd0); arready_d = 1'b0; rvalid_d = 1'b1; r_state_d = R_DATA;
      end
      R_DATA: if (rready && rvalid_q) begin
        if (rlast_q) begin
          rvalid_d = 1'b0; rlast_d = 1'b0; arready_d = 1'b1; r_state_d = R_IDLE;
        end else begin
          rd_addr = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
          raddr_d = rd_addr; rd_load = 1'b1;
          rcnt_d  = rcnt_q + 8'd1;
          rlast_d = (rcnt_d == rlen_q);
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    // Combinational RAM read: a write landing on the same edge is not yet visible.
    rd_oob = rd_addr >= MEM_BYTES;
    if (rd_load) begin
      rresp_d = resp_max(rbad_d ? RESP_SLVERR : RESP_OKAY, rd_oob ? RESP_DECERR : RESP_OKAY);
      rdata_d = (rbad_d || rd_oob) ? '0 : mem[rd_addr[BSH +: MAW]];
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state_q <= R_IDLE; arready_q <= 1'b1; rvalid_q <= 1'b0; rlast_q <= 1'b0;
      rid_q <= '0; rdata_q <= '0; rresp_q <= RESP_OKAY; rburst_q <= '0;
      raddr_q <= '0; rlen_q <= '0; rcnt_q <= '0; rsize_q <= '0; rbad_q <= 1'b0;
    end else begin
      r_state_q <= r_state_d; arready_q <= arready_d; rvalid_q <= rvalid_d; rlast_q <= rlast_d;
      rid_q <= rid_d; rdata_q <= rdata_d; rresp_q <= rresp_d; rburst_q <= rburst_d;
      raddr_q <= raddr_d; rlen_q <= rlen_d; rcnt_q <= rcnt_d; rsize_q <= rsize_d; rbad_q <= rbad_d;
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
endmodule

// File: tb/tb_ei_axi4_slave_mem.sv
// Bench for ei_axi4_slave_mem (default parameters: 32-bit data, 1024 words).
// A byte-level memory model plus closed-form beat addresses provide every
// expected B/R value; directed scenarios are followed by a random mix.
module tb_ei_axi4_slave_mem;
  localparam int TMO = 300;

  logic        aclk = 1'b0, areset = 1'b1;
  logic [3:0]  awid = '0, arid = '0, bid, rid;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
  logic [7:0]  awlen = '0, arlen = '0;
  logic [2:0]  awsize = '0, arsize = '0;
  logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
  logic        awvalid = 1'b0, awready, arvalid = 1'b0, arready;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0, wvalid = 1'b0, wready, bvalid, bready = 1'b0;
  logic        rlast, rvalid, rready = 1'b0;

  int total = 0, bad = 0;
  logic [31:0] mdl [1024];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];

  ei_axi4_slave_mem dut (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic par_bad(input int len, input int size, input int burst);
    return burst == 3 || size > 2 || (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  function automatic logic [1:0] rmax(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Byte address of beat i, straight from the burst definitions.
  function automatic int unsigned beat_addr(input int unsigned st, input int len,
      input int size, input int burst, input int i);
    int unsigned nb, wb, lo;
    nb = 1 << size;
    case (burst)
      0: return st;
      2: begin
        wb = (len + 1) * nb;
        lo = st - (st % wb);
        return lo + ((st - lo) + i * nb) % wb;
      end
      default: return (i == 0) ? st : (st - st % nb) + i * nb;
    endcase
  endfunction

  // flip: index of the beat whose wlast is inverted, or -1.
  task automatic axi_wr(input logic [3:0] id, input int unsigned addr, input int len,
      input int size, input int burst, input int flip);
    int n; logic [1:0] er; logic pb; int unsigned a;
    pb = par_bad(len, size, burst);
    er = pb ? 2'b10 : 2'b00;
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, len, size, burst, i);
      if (i == flip) er = rmax(er, 2'b10);
      if (a >= 4096) er = rmax(er, 2'b11);
      else if (!pb)
        for (int b = 0; b < 4; b++) if (ws[i][b]) mdl[a/4][8*b +: 8] = wd[i][8*b +: 8];
    end
    @(negedge aclk);
    awvalid = 1'b1; awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst);
    n = 0;
    while (!awready && n < TMO) begin @(negedge aclk); n++; end
    if (n >= TMO) chk("aw_timeout", 0, 1);
    @(negedge aclk);
    awvalid = 1'b0;
    chk("awready_busy", awready, 0);
    for (int i = 0; i <= len; i++) begin
      wvalid = 1'b0;
      repeat ($urandom_range(0, 1)) @(negedge aclk);
      wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == len) ^ (i == flip);
      n = 0;
      while (!wready && n < TMO) begin @(negedge aclk); n++; end
      if (n >= TMO) chk("w_timeout", 0, 1);
      @(negedge aclk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("bvalid", bvalid, 1);
    chk("wready_end", wready, 0);
    repeat ($urandom_range(0, 2)) @(negedge aclk);
    chk("bid", bid, id);
    chk("bresp", bresp, er);
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    chk("bvalid_clr", bvalid, 0);
    chk("awready_back", awready, 1);
  endtask

  // mode: 0 no stall, 1 random stalls, 2 stall on every odd beat.
  task automatic axi_rd(input logic [3:0] id, input int unsigned addr, input int len,
      input int size, input int burst, input int mode);
    int n; logic pb, oob, stall; int unsigned a; logic [31:0] ed; logic [1:0] er;
    pb = par_bad(len, size, burst);
    @(negedge aclk);
    arvalid = 1'b1; arid = id; araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst);
    n = 0;
    while (!arready && n < TMO) begin @(negedge aclk); n++; end
    if (n >= TMO) chk("ar_timeout", 0, 1);
    @(negedge aclk);
    arvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      a   = beat_addr(addr, len, size, burst, i);
      oob = a >= 4096;
      ed  = (pb || oob) ? 32'h0 : mdl[a/4];
      er  = rmax(pb ? 2'b10 : 2'b00, oob ? 2'b11 : 2'b00);
      chk("rvalid", rvalid, 1);
      stall = (mode == 2) ? (i % 2 == 1) : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (stall) begin rready = 1'b0; @(negedge aclk); end
      chk("rdata", rdata, ed);
      chk("rresp", rresp, er);
      chk("rlast", rlast, i == len);
      chk("rid", rid, id);
      rready = 1'b1;
      @(negedge aclk);
    end
    rready = 1'b0;
    chk("rvalid_clr", rvalid, 0);
    chk("arready_back", arready, 1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: sim time limit reached, total=%0d", total);
    $fatal(1);
  end

  initial begin
    int unsigned addr; int len, size, burst, flip, nb;
    for (int i = 0; i < 1024; i++) mdl[i] = '0;
    repeat (2) @(negedge aclk);
    chk("rst_awready", awready, 1);
    chk("rst_arready", arready, 1);
    chk("rst_valids", {wready, bvalid, rvalid, rlast}, 4'b0);
    chk("rst_resp", {bresp, rresp, bid, rid}, 12'h0);
    chk("rst_rdata", rdata, 0);
    areset = 1'b0;

    // Give the whole RAM known contents.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      axi_wr(4'(k), k * 1024, 255, 2, 1, -1);
    end

    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    axi_wr(4'h3, 32'h10, 0, 2, 1, -1);
    axi_rd(4'h5, 32'h10, 0, 2, 1, 0);

    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    axi_wr(4'h1, 32'h100, 3, 2, 1, -1);
    axi_rd(4'h2, 32'h100, 3, 2, 1, 2);

    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA + 32'(i); ws[i] = 4'hF; end
    axi_wr(4'h6, 32'h1C, 3, 2, 2, -1);
    axi_rd(4'h6, 32'h10, 3, 2, 1, 0);
    for (int i = 0; i < 3; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    axi_wr(4'h7, 32'h10, 2, 2, 2, -1);
    axi_rd(4'h7, 32'h10, 3, 2, 1, 0);

    wd[0] = 32'h12345678; ws[0] = 4'hF;
    axi_wr(4'h8, 32'h1000, 0, 2, 1, -1);
    axi_rd(4'h8, 32'h1000, 0, 2, 1, 0);

    wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
    axi_wr(4'h9, 32'h200, 0, 2, 1, -1);
    wd[0] = 32'h00001234; ws[0] = 4'h3;
    axi_wr(4'h9, 32'h200, 0, 2, 1, -1);
    axi_rd(4'h9, 32'h200, 0, 2, 1, 0);
    chk("strb_word", mdl[32'h200/4], 32'hFFFF1234);
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    axi_wr(4'hA, 32'h300, 3, 2, 1, 1);
    axi_rd(4'hA, 32'h300, 3, 2, 1, 1);

    // Reset while beat 2 of an 8-beat read is on the bus.
    @(negedge aclk);
    arvalid = 1'b1; arid = 4'hB; araddr = 32'h400; arlen = 8'd7; arsize = 3'd2; arburst = 2'd1;
    @(negedge aclk);
    arvalid = 1'b0;
    rready = 1'b1;
    repeat (2) @(negedge aclk);
    chk("pre_rst_rdata", rdata, mdl[32'h408/4]);
    rready = 1'b0; areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    chk("midrst_rvalid", rvalid, 0);
    chk("midrst_arready", arready, 1);
    chk("midrst_rlast_rdata", {rlast, rdata}, 33'h0);
    axi_rd(4'hC, 32'h400, 7, 2, 1, 1);

    for (int it = 0; it < 60; it++) begin
      burst = ($urandom_range(0, 19) == 0) ? 3 : int'($urandom_range(0, 2));
      size  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(3, 7)) : int'($urandom_range(0, 2));
      if (burst == 2) begin
        case ($urandom_range(0, 4))
          0: len = 1;  1: len = 3;  2: len = 7;  3: len = 15;  default: len = 2;
        endcase
      end else len = int'($urandom_range(0, 15));
      if (par_bad(len, size, burst)) begin
        addr = $urandom_range(0, 2047);
        len  = len & 7;
      end else begin
        case ($urandom_range(0, 9))
          0: addr = $urandom_range(4096, 8191);
          1: addr = $urandom_range(4032, 4095);
          default: addr = $urandom_range(0, 4095);
        endcase
      end
      nb = 1 << size;
      if (burst == 2) addr = addr & ~(nb - 1);
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
        flip = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len)) : -1;
        axi_wr(4'($urandom), addr, len, size, burst, flip);
      end else
        axi_rd(4'($urandom), addr, len, size, burst, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ei_axi4_slave_mem.md
Name: ei_axi4_slave_mem

Overview:
- Synthesizable AXI4 slave memory: the DUT that ei_axi4_interface connects to. The VIP master drives it, and the VIP monitor/scoreboard checks it.
- Five channels: AW, W, B, AR, R. Word-addressed internal RAM.
- Read and write paths are independent FSMs. Each path accepts one outstanding transaction at a time.
- Supports FIXED, INCR and WRAP bursts, len 0..255.

Parameters:
- ADDR_WIDTH, 32, awaddr/araddr width.
- DATA_WIDTH, 32, data bus width; 32 or 64 only. BYTES = DATA_WIDTH/8.
- ID_WIDTH, 4, transaction ID width.
- MEM_DEPTH, 1024, number of DATA_WIDTH-bit words; power of 2.

Ports:
- aclk  input  1  sole clock; all logic on rising edge.
- areset  input  1  synchronous, active-high reset.
- awid, arid  input  ID_WIDTH  write/read address IDs.
- awaddr, araddr  input  ADDR_WIDTH  byte start addresses.
- awlen, arlen  input  8  beats-1.
- awsize, arsize  input  3  log2 bytes per beat.
- awburst, arburst  input  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- awvalid/awready, arvalid/arready  in/out  1  address handshakes.
- wdata  input  DATA_WIDTH  write data.
- wstrb  input  BYTES  byte-lane enables.
- wlast  input  1  last write beat.
- wvalid/wready  in/out  1  write data handshake.
- bid  output  ID_WIDTH  echoes captured awid.
- bresp  output  2  00 OKAY, 10 SLVERR, 11 DECERR.
- bvalid/bready  out/in  1  write response handshake.
- rid  output  ID_WIDTH  echoes captured arid.
- rdata  output  DATA_WIDTH  read data.
- rresp  output  2  per-beat response; same encoding as bresp.
- rlast  output  1  marks beat arlen.
- rvalid/rready  out/in  1  read data handshake.

Behaviour:
- Reset (synchronous, sampled at posedge, areset=1):
  - Outputs next edge: awready=arready=1, wready=bvalid=rvalid=rlast=0, bresp=rresp=0, bid=rid=0, rdata=0.
  - Both FSMs go to IDLE. RAM contents are not reset.
  - Reset mid-burst aborts the burst with no B/R completion. Writes already committed remain.
- Handshake rule: a transfer occurs on an edge where valid&ready=1. Outputs are registered. Valid outputs and their payload hold stable until the handshake completes.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1. AW handshake captures id/addr/len/size/burst and clears the error flag and beat count. awready=0 and wready=1 from the next cycle.
  - W_DATA: each W handshake writes the lanes with wstrb=1 into word (addr/BYTES) mod MEM_DEPTH, then advances the address.
  - The beat at count==len ends the burst: wready=0, bvalid=1 next cycle.
  - wlast mismatch (wlast=1 before count==len, or wlast=0 at count==len) sets SLVERR. The burst still ends at count==len.
  - W_RESP: bvalid held until bready. Return to W_IDLE; awready=1 the cycle after the B handshake.
- Read FSM R_IDLE -> R_DATA -> R_IDLE:
  - AR handshake at edge N: RAM read; rvalid=1 with beat 0 at N+1.
  - Each R handshake presents the next beat the following cycle, giving one beat per cycle while rready=1.
  - rlast=1 only on beat arlen. After the last handshake: rvalid=0, arready=1.
- Address sequencing:
  - FIXED: address constant.
  - INCR: next = (addr aligned to size) + (1<<size).
  - WRAP: boundary = (len+1)<<size; the address wraps to the aligned lower bound when it reaches lower+boundary.
  - Narrow reads return the full word. The master selects lanes.
- Errors:
  - Reserved burst, size > log2(BYTES), or WRAP with len not in {1,3,7,15}: SLVERR for the whole transaction. All RAM writes are suppressed. Beats are still accepted/returned (rdata=0).
  - Beat address >= MEM_DEPTH*BYTES: that beat DECERR and not written; read data 0. bresp takes the highest severity seen: DECERR > SLVERR > OKAY.
- Same-cycle write and read to the same word: the read returns the pre-write value.
- Simultaneous AW and AR handshakes are both accepted; the channels are independent.

Test Plan:
- Single write awaddr=0x10, len=0, INCR, size=2, wdata=0xDEADBEEF, wstrb=0xF; then read araddr=0x10 -> bresp=00, rdata=0xDEADBEEF, rlast=1, rvalid one cycle after AR handshake.
- INCR len=3 at 0x100, data 1..4, then read back with rready toggling 1,0,1,0 -> rdata 1,2,3,4 held stable while stalled, rlast only on beat 3.
- WRAP len=3 size=2 at 0x1C writing A,B,C,D -> words 0x1C,0x10,0x14,0x18 hold A,B,C,D; WRAP len=2 -> bresp=10, no RAM change.
- Write to 0x1000 (MEM_DEPTH=1024, 32-bit) -> bresp=11; read there -> rresp=11, rdata=0.
- wstrb=0x3 over 0xFFFFFFFF with 0x00001234 -> readback 0xFFFF1234; early wlast on len=3 -> bresp=10.
- areset=1 for one cycle during beat 2 of a len=7 read -> rvalid=0 next edge, arready=1; a new read completes normally.
